arbiter_rr: RTL and testbench
=============================

ARBITER_RR -- requirements
Module: arbiter_rr

Interface
REQ-001 SHALL have parameter N_PORTS, default 5, number of requesting ports (2..16).
REQ-002 SHALL have parameter MAX_HOLD, default 4, max consecutive grants to one port when sticky mode is compiled in (1..15).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port Req  input  N_PORTS  per-port request, level.
REQ-006 SHALL have port DCTS  input  1  downstream clear-to-send.
REQ-007 SHALL have port Grant  output  N_PORTS  one-hot grant pulse.
REQ-008 SHALL have port Xbar_sel  output  N_PORTS  one-hot crossbar select.
REQ-009 SHALL have port RTS  output  1  request-to-send, registered.

Function
REQ-010 SHALL implement FSM states IDLE, SETUP, SEND.
REQ-011 IDLE: RTS=0, Xbar_sel=0; if any Req bit is high, SHALL latch the winner and move to SETUP next cycle; otherwise stay in IDLE.
REQ-012 SETUP: Xbar_sel=onehot(winner), RTS=0 (one-cycle turnaround); SHALL move to SEND unconditionally.
REQ-013 SEND: RTS=1, Xbar_sel=onehot(winner); DCTS=0 SHALL hold SEND with outputs stable, no cycle limit.
REQ-014 SEND with DCTS=1: Grant SHALL equal onehot(winner) combinationally in that cycle only; next state SHALL be SETUP with a new winner if any Req bit is high, else IDLE.
REQ-015 Grant SHALL be all-zero in every cycle other than SEND with DCTS=1; at most one Grant bit high ever.
REQ-016 Winner selection SHALL be round-robin: search Req from index ptr upward with wrap-around modulo N_PORTS; lowest index at or after ptr wins.
REQ-017 On each completed handshake, ptr SHALL become (winner+1) mod N_PORTS.
REQ-018 A Req bit that drops while its port is in SETUP/SEND SHALL NOT abort the transfer; the grant is still issued to the latched winner.
REQ-019 Req SHALL be sampled only in IDLE and on the DCTS=1 cycle of SEND; changes at other times SHALL have no effect.
REQ-020 Minimum throughput SHALL be one Grant per 2 cycles under continuous Req and DCTS=1.

Reset
REQ-021 Asserting rst SHALL immediately force state=IDLE, ptr=0, hold counter=0, RTS=0, Grant=0, Xbar_sel=0, including mid-SEND.
REQ-022 After rst deasserts, first arbitration SHALL occur on the first rising clk edge with rst low.

Configuration
REQ-023 Macro ARB_STICKY_EN SHALL select sticky mode.
REQ-024 With ARB_STICKY_EN defined: at the DCTS=1 cycle, if the current winner's Req is high and its consecutive-grant count is below MAX_HOLD, it SHALL win again and ptr SHALL NOT advance; count resets to 1 on a winner change; on reaching MAX_HOLD, selection SHALL start from winner+1.
REQ-025 Without ARB_STICKY_EN: strict round-robin per REQ-016/017; MAX_HOLD ignored; no hold counter synthesised.

Structure
REQ-026 Package arb_pkg SHALL hold the FSM state typedef (enum IDLE/SETUP/SEND) and default parameter constants.
REQ-027 Combinational sub-module rr_pick SHALL compute the one-hot winner from Req, ptr and N_PORTS; arbiter_rr holds FSM, ptr, hold counter.
REQ-028 ptr width SHALL be $clog2(N_PORTS); hold counter width $clog2(MAX_HOLD+1).

Verification (N_PORTS=5, MAX_HOLD=3)
REQ-029 rst pulsed during SEND with DCTS=0 -> RTS, Grant, Xbar_sel all 0 before next edge; next Req=5'b00100 -> Grant=5'b00100 granted first.
REQ-030 Strict mode, Req=5'b10101 constant, DCTS=1 -> Grant sequence 00001,00100,10000,00001, one pulse every 2 cycles.
REQ-031 SEND entered, DCTS=0 for 10 cycles then 1 -> RTS=1 and Xbar_sel stable for 10 cycles, Grant=0, then exactly one Grant pulse.
REQ-032 Sticky build, Req=5'b00011 constant, DCTS=1 -> Grant 00001 x3, then 00010 x3, then 00001.
REQ-033 Req=5'b01000 dropped to 0 in SETUP, DCTS=1 -> Grant=5'b01000 issued once, then IDLE.
REQ-034 Req=5'b11111 from reset, strict, DCTS=1 -> Grant order 00001,00010,00100,01000,10000,00001.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and default sizing for the round-robin crossbar arbiter.
package arb_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, SEND} state_t;

  localparam int N_PORTS_DEF  = 5;
  localparam int MAX_HOLD_DEF = 4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after base, wrapping
// modulo N_PORTS. Returns the winner as one-hot and as an index.
module rr_pick #(
  parameter int N_PORTS = 5,
  parameter int PW      = $clog2(N_PORTS)
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [PW-1:0]      base,
  output logic [N_PORTS-1:0] onehot,
  output logic [PW-1:0]      idx,
  output logic               any
);

  localparam logic [PW:0] NP = (PW+1)'(N_PORTS);

  logic [N_PORTS-1:0] rot;
  logic [PW-1:0]      off;
  logic [PW:0]        sum;

  always_comb begin
    // Rotate so that bit 0 is the port at base; the lowest set bit is then the winner.
    rot = N_PORTS'({req, req} >> base);
    off = '0;
    any = 1'b0;
    for (int i = N_PORTS-1; i >= 0; i--) begin
      if (rot[i]) begin
        off = PW'(i);
        any = 1'b1;
      end
    end
    sum = {1'b0, base} + {1'b0, off};
    if (sum >= NP) sum = sum - NP;
    idx    = sum[PW-1:0];
    onehot = any ? (N_PORTS'(1) << idx) : '0;
  end

endmodule

// File: rtl/arbiter_rr.sv
// Round-robin crossbar arbiter with IDLE/SETUP/SEND handshake to a downstream sink.
// Define ARB_STICKY_EN to let a winner keep the port for up to MAX_HOLD grants.
module arbiter_rr
  import arb_pkg::*;
#(
  parameter int N_PORTS  = N_PORTS_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_PORTS-1:0] Req,
  input  logic               DCTS,
  output logic [N_PORTS-1:0] Grant,
  output logic [N_PORTS-1:0] Xbar_sel,
  output logic               RTS
);

  localparam int PW = $clog2(N_PORTS);

  if (N_PORTS < 2 || N_PORTS > 16 || MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_bad_cfg
    $error("arbiter_rr: parameter out of range");
  end

  state_t             state, state_nxt;
  logic [PW-1:0]      ptr, win, base, wp1, pick_idx;
  logic [N_PORTS-1:0] win_oh, pick_oh;
  logic               pick_any, load, hs, stick_ok;

  rr_pick #(.N_PORTS(N_PORTS), .PW(PW)) u_pick (
    .req    (Req),
    .base   (base),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign wp1 = (win == PW'(N_PORTS-1)) ? '0 : win + 1'b1;

`ifdef ARB_STICKY_EN
  localparam int HW = $clog2(MAX_HOLD+1);
  logic [HW-1:0] cnt;

  // cnt includes the grant currently pending for win.
  assign stick_ok = Req[win] && (cnt < HW'(MAX_HOLD));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  cnt <= '0;
    else if (load)            cnt <= HW'(1);
    else if (hs && stick_ok)  cnt <= cnt + 1'b1;
    else if (hs)              cnt <= '0;
  end
`else
  assign stick_ok = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    Grant     = '0;
    Xbar_sel  = '0;
    base      = ptr;
    load      = 1'b0;
    hs        = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          load      = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        Xbar_sel  = win_oh;
        state_nxt = SEND;
      end
      SEND: begin
        Xbar_sel = win_oh;
        if (DCTS) begin
          Grant = win_oh;
          hs    = 1'b1;
          // Re-arbitrate from the port after the one just served.
          base  = wp1;
          if (stick_ok) begin
            state_nxt = SETUP;
          end else if (pick_any) begin
            load      = 1'b1;
            state_nxt = SETUP;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= '0;
      win    <= '0;
      win_oh <= '0;
      RTS    <= 1'b0;
    end else begin
      state <= state_nxt;
      RTS   <= (state_nxt == SEND);
      if (load) begin
        win    <= pick_idx;
        win_oh <= pick_oh;
      end
      if (hs && !stick_ok) ptr <= wp1;
    end
  end

endmodule

// File: tb/tb_arbiter_rr.sv
// Bench for arbiter_rr: grant-order tables, handshake corner cases, and a
// randomized run against a transaction-level reference model.
module tb_arbiter_rr;
  localparam int N  = 5;
  localparam int MH = 3;
`ifdef ARB_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] Req, Grant, Xbar_sel;
  logic         DCTS, RTS;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  arbiter_rr #(.N_PORTS(N), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .Req(Req), .DCTS(DCTS),
    .Grant(Grant), .Xbar_sel(Xbar_sel), .RTS(RTS)
  );

  typedef struct {
    logic         rst_first;
    logic [N-1:0] req;
    logic         dcts;
    logic [N-1:0] g;
    logic [N-1:0] x;
    logic         rts;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst  = 1'b1;
    Req  = '0;
    DCTS = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Idle row, then a SETUP/SEND pair per winner; winners packed as nibbles, first in LSBs.
  task automatic add_seq(input logic [N-1:0] r, input int nw, input logic [31:0] wl);
    vec_t v;
    logic [N-1:0] oh;
    v = '{1'b1, r, 1'b1, '0, '0, 1'b0};
    tbl.push_back(v);
    for (int i = 0; i < nw; i++) begin
      oh = '0;
      oh[wl[4*i +: 4]] = 1'b1;
      v = '{1'b0, r, 1'b1, '0, oh, 1'b0};
      tbl.push_back(v);
      v = '{1'b0, r, 1'b1, oh, oh, 1'b1};
      tbl.push_back(v);
    end
  endtask

  // Reference model: phase 0 = waiting, 1 = turnaround, 2 = offering to downstream.
  int m_phase, m_win, m_ptr, m_cnt;

  function automatic int rr_find(input logic [N-1:0] r, input int from);
    for (int k = 0; k < N; k++)
      if (r[(from + k) % N]) return (from + k) % N;
    return -1;
  endfunction

  task automatic model_reset;
    m_phase = 0; m_win = 0; m_ptr = 0; m_cnt = 0;
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic d);
    int j;
    if (m_phase == 0) begin
      j = rr_find(r, m_ptr);
      if (j >= 0) begin m_win = j; m_cnt = 1; m_phase = 1; end
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else if (d) begin
      if (STICKY && r[m_win] && m_cnt < MH) begin
        m_cnt++;
        m_phase = 1;
      end else begin
        m_ptr = (m_win + 1) % N;
        j = rr_find(r, m_ptr);
        if (j >= 0) begin m_win = j; m_cnt = 1; m_phase = 1; end
        else begin m_phase = 0; m_cnt = 0; end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] oh;
    rst = 1'b1; Req = '0; DCTS = 1'b0;
    #1;
    chk("reset grant", Grant, 0);
    chk("reset xbar", Xbar_sel, 0);
    chk("reset rts", RTS, 0);

`ifdef ARB_STICKY_EN
    add_seq(5'b00011, 7, 32'h0111000);
`else
    add_seq(5'b11111, 6, 32'h043210);
    add_seq(5'b10101, 4, 32'h0420);
`endif
    foreach (tbl[i]) begin
      if (tbl[i].rst_first) do_reset();
      Req  = tbl[i].req;
      DCTS = tbl[i].dcts;
      #1;
      chk($sformatf("tbl[%0d] grant", i), Grant, tbl[i].g);
      chk($sformatf("tbl[%0d] xbar", i), Xbar_sel, tbl[i].x);
      chk($sformatf("tbl[%0d] rts", i), RTS, tbl[i].rts);
      tick();
    end

    // Long DCTS stall in SEND, then exactly one grant.
    do_reset();
    Req = 5'b00100; DCTS = 1'b0;
    tick(); tick();
    Req = '0;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("stall rts", RTS, 1);
      chk("stall xbar", Xbar_sel, 5'b00100);
      chk("stall grant", Grant, 0);
      tick();
    end
    DCTS = 1'b1;
    #1;
    chk("stall release grant", Grant, 5'b00100);
    tick(); #1;
    chk("stall after grant", Grant, 0);
    chk("stall after rts", RTS, 0);

    // Requester withdraws during SETUP; transfer still completes.
    do_reset();
    Req = 5'b01000; DCTS = 1'b1;
    tick();
    Req = '0;
    #1;
    chk("drop setup xbar", Xbar_sel, 5'b01000);
    tick(); #1;
    chk("drop send grant", Grant, 5'b01000);
    tick(); #1;
    chk("drop idle grant", Grant, 0);
    chk("drop idle xbar", Xbar_sel, 0);
    chk("drop idle rts", RTS, 0);

    // Reset while stalled in SEND; pointer must restart at port 0.
    do_reset();
    Req = 5'b00010; DCTS = 1'b0;
    tick();
    Req = '0;
    tick();
    DCTS = 1'b1;
    #1;
    chk("rst pre grant", Grant, 5'b00010);
    tick();
    DCTS = 1'b0; Req = 5'b00100;
    tick(); tick(); #1;
    chk("rst pre rts", RTS, 1);
    rst = 1'b1; DCTS = 1'b1;
    #1;
    chk("rst mid rts", RTS, 0);
    chk("rst mid grant", Grant, 0);
    chk("rst mid xbar", Xbar_sel, 0);
    @(negedge clk);
    rst = 1'b0; Req = 5'b00101;
    #1;
    chk("rst post idle rts", RTS, 0);
    tick(); #1;
    chk("rst post setup xbar", Xbar_sel, 5'b00001);
    tick(); #1;
    chk("rst post grant", Grant, 5'b00001);

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 400; c++) begin
      Req  = N'($urandom);
      DCTS = ($urandom_range(0, 3) != 0);
      #1;
      oh = '0;
      oh[m_win] = 1'b1;
      chk("rand xbar", Xbar_sel, (m_phase != 0) ? oh : '0);
      chk("rand rts", RTS, m_phase == 2);
      chk("rand grant", Grant, (m_phase == 2 && DCTS) ? oh : '0);
      chk("rand grant onehot", $countones(Grant) <= 1, 1);
      model_step(Req, DCTS);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
